// File: rtl/and2_exerciser_pkg.sv
// Shared definitions for the 2-input AND gate exerciser: FSM encoding and sizing constants.
package and2_exerciser_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    localparam int unsigned NUM_VEC = 4;
    localparam int unsigned ERR_W   = 3;
    localparam int unsigned CNT_W   = 4;

endpackage

// File: rtl/and2_settle_timer.sv
// Settle-wait down-counter: loads a start value, decrements to zero and flags zero.
module and2_settle_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/and2_exerciser.sv
// Drives AB = 00,01,10,11 into an external AND gate, checks F after SETTLE cycles, reports PASS/ERR_CNT.
// Optional first-failure capture ports are enabled by defining AND2_EXERCISER_FAILCAP_EN.
module and2_exerciser
    import and2_exerciser_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    output logic             A,
    output logic             B,
    input  logic             F,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
`ifdef AND2_EXERCISER_FAILCAP_EN
    output logic             FAIL_VALID,
    output logic [1:0]       FAIL_VEC,
`endif
    output logic [ERR_W-1:0] ERR_CNT
);

    state_t state, state_next;
    logic [1:0]       vec;
    logic             last_vec;
    logic             mismatch;
    logic             tmr_load;
    logic             tmr_dec;
    logic             tmr_zero;
    logic [CNT_W-1:0] tmr_cnt;

    assign last_vec = (vec == 2'(NUM_VEC - 1));
    assign mismatch = (F != (A & B));

    assign tmr_load = (state == S_IDLE && START) || (state == S_SAMPLE && !last_vec);
    assign tmr_dec  = (state == S_SETTLE);

    and2_settle_timer #(.W(CNT_W)) u_timer (
        .clk      (CLK),
        .rst      (RST),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (CNT_W'(SETTLE - 1)),
        .cnt      (tmr_cnt),
        .zero     (tmr_zero)
    );

    always_ff @(posedge CLK) begin
        if (RST)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (START) state_next = S_SETTLE;
            S_SETTLE: if (tmr_zero) state_next = S_SAMPLE;
            S_SAMPLE: state_next = last_vec ? S_FIN : S_SETTLE;
            S_FIN:    state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state != S_IDLE);
        DONE = (state == S_FIN);
    end

    // Datapath: vector register, operand outputs, mismatch count and verdict.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vec     <= '0;
            A       <= 1'b0;
            B       <= 1'b0;
            ERR_CNT <= '0;
            PASS    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        vec     <= '0;
                        A       <= 1'b0;
                        B       <= 1'b0;
                        ERR_CNT <= '0;
                        PASS    <= 1'b0;
                    end
                end
                S_SAMPLE: begin
                    if (mismatch && ERR_CNT < ERR_W'(NUM_VEC))
                        ERR_CNT <= ERR_CNT + 1'b1;
                    if (!last_vec) begin
                        vec      <= vec + 2'd1;
                        {A, B}   <= vec + 2'd1;
                    end
                end
                S_FIN: begin
                    PASS <= (ERR_CNT == '0);
                    A    <= 1'b0;
                    B    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef AND2_EXERCISER_FAILCAP_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            FAIL_VALID <= 1'b0;
            FAIL_VEC   <= '0;
        end else if (state == S_IDLE && START) begin
            FAIL_VALID <= 1'b0;
            FAIL_VEC   <= '0;
        end else if (state == S_SAMPLE && mismatch && !FAIL_VALID) begin
            FAIL_VALID <= 1'b1;
            FAIL_VEC   <= vec;
        end
    end
`endif

endmodule

// File: tb/tb_and2_exerciser.sv
// Scoreboard bench for and2_exerciser (SETTLE=2) with a behavioural gate under test on F.
module tb_and2_exerciser;

    localparam int unsigned SETTLE = 2;

    typedef struct {
        logic [2:0] err;
        logic       pass;
        logic       fvalid;
        logic [1:0] fvec;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic       A, B, F, BUSY, DONE, PASS;
    logic [2:0] ERR_CNT;
    logic [1:0] mode = 2'd0;
`ifdef AND2_EXERCISER_FAILCAP_EN
    logic       FAIL_VALID;
    logic [1:0] FAIL_VEC;
`endif

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    // Gate under test: 0 = AND, 1 = stuck-0, 2 = stuck-1, 3 = NAND
    function automatic logic gate_f(input logic [1:0] m, input logic a, input logic b);
        case (m)
            2'd0:    gate_f = a & b;
            2'd1:    gate_f = 1'b0;
            2'd2:    gate_f = 1'b1;
            default: gate_f = ~(a & b);
        endcase
    endfunction

    assign F = gate_f(mode, A, B);

    and2_exerciser #(.SETTLE(SETTLE)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .A          (A),
        .B          (B),
        .F          (F),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .PASS       (PASS),
`ifdef AND2_EXERCISER_FAILCAP_EN
        .FAIL_VALID (FAIL_VALID),
        .FAIL_VEC   (FAIL_VEC),
`endif
        .ERR_CNT    (ERR_CNT)
    );

    function automatic exp_t predict(input logic [1:0] m);
        exp_t e;
        logic [1:0] kv;
        e.err = 0; e.fvalid = 0; e.fvec = 0;
        for (int k = 0; k < 4; k++) begin
            kv = 2'(k);
            if (gate_f(m, kv[1], kv[0]) != (kv[1] & kv[0])) begin
                if (!e.fvalid) begin
                    e.fvalid = 1'b1;
                    e.fvec   = kv;
                end
                e.err = e.err + 3'd1;
            end
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        tests++;
        if ({BUSY, DONE, PASS, A, B, ERR_CNT} !== 8'b0) begin
            fails++;
            $display("FAIL reset_state: got busy/done/pass/a/b/err=%b required 0", {BUSY, DONE, PASS, A, B, ERR_CNT});
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    // One full run; optionally re-pulses START in cycle restart_cyc (ignored while busy).
    task automatic run_vectors(input string name, input logic [1:0] m, input int restart_cyc);
        exp_t e;
        int   cyc, done_cyc;
        logic [1:0] exp_ab;
        sb.push_back(predict(m));
        mode  = m;
        START = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        cyc = 1;
        done_cyc = 0;
        while (done_cyc == 0 && cyc < 40) begin
            START = (cyc == restart_cyc);
            if (cyc <= 12) begin
                exp_ab = 2'((cyc - 1) / (SETTLE + 1));
                tests++;
                if ({A, B} !== exp_ab || BUSY !== 1'b1) begin
                    fails++;
                    $display("FAIL %s vec_c%0d: got ab=%b busy=%b required ab=%b busy=1", name, cyc, {A, B}, BUSY, exp_ab);
                end
            end
            if (DONE === 1'b1) done_cyc = cyc;
            else begin
                @(negedge CLK);
                cyc++;
            end
        end
        START = 1'b0;
        tests++;
        if (done_cyc != 13) begin
            fails++;
            $display("FAIL %s done_cycle: got %0d required 13", name, done_cyc);
        end
        e = sb.pop_front();
        tests++;
        if (ERR_CNT !== e.err) begin
            fails++;
            $display("FAIL %s err_cnt: got %0d required %0d", name, ERR_CNT, e.err);
        end
`ifdef AND2_EXERCISER_FAILCAP_EN
        tests++;
        if (FAIL_VALID !== e.fvalid || (e.fvalid && FAIL_VEC !== e.fvec)) begin
            fails++;
            $display("FAIL %s failcap: got v=%b vec=%b required v=%b vec=%b", name, FAIL_VALID, FAIL_VEC, e.fvalid, e.fvec);
        end
`endif
        @(negedge CLK);
        tests++;
        if (PASS !== e.pass || BUSY !== 1'b0 || DONE !== 1'b0 || {A, B} !== 2'b00) begin
            fails++;
            $display("FAIL %s post_run: got pass=%b busy=%b done=%b ab=%b required pass=%b busy=0 done=0 ab=00",
                     name, PASS, BUSY, DONE, {A, B}, e.pass);
        end
    endtask

    task automatic test_correct();   run_vectors("and_ok",  2'd0, 0); endtask
    task automatic test_stuck0();    run_vectors("stuck0",  2'd1, 0); endtask
    task automatic test_stuck1();    run_vectors("stuck1",  2'd2, 0); endtask
    task automatic test_nand();      run_vectors("nand",    2'd3, 0); endtask
    task automatic test_restart();   run_vectors("restart", 2'd1, 5); endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc, ndone;
        sb.push_back(predict(2'd0));
        sb.push_back(predict(2'd0));
        mode  = 2'd0;
        START = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        cyc = 1;
        ndone = 0;
        while (cyc < 60 && ndone < 2) begin
            if (cyc == 14 || cyc == 15) begin
                tests++;
                if (BUSY !== (cyc == 15) || (cyc == 14 && PASS !== 1'b1)) begin
                    fails++;
                    $display("FAIL b2b_gap_c%0d: got busy=%b pass=%b", cyc, BUSY, PASS);
                end
            end
            if (DONE === 1'b1) begin
                e = sb.pop_front();
                tests++;
                if (cyc != (ndone == 0 ? 13 : 27) || ERR_CNT !== e.err) begin
                    fails++;
                    $display("FAIL b2b_done%0d: got cycle=%0d err=%0d required cycle=%0d err=%0d",
                             ndone, cyc, ERR_CNT, (ndone == 0 ? 13 : 27), e.err);
                end
                ndone++;
                if (ndone == 2) START = 1'b0;
            end
            @(negedge CLK);
            cyc++;
        end
        START = 1'b0;
        tests++;
        if (ndone != 2) begin
            fails++;
            $display("FAIL b2b_timeout: got %0d runs required 2", ndone);
        end
        @(negedge CLK);
        tests++;
        if (BUSY !== 1'b0 || PASS !== 1'b1) begin
            fails++;
            $display("FAIL b2b_stop: got busy=%b pass=%b required busy=0 pass=1", BUSY, PASS);
        end
    endtask

    task automatic test_reset_midrun();
        int saw_done;
        mode  = 2'd3;
        START = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        repeat (6) @(negedge CLK);
        tests++;
        if (ERR_CNT !== 3'd2) begin
            fails++;
            $display("FAIL rst_mid_pre: got err=%0d required 2", ERR_CNT);
        end
        RST   = 1'b1;
        START = 1'b1;
        @(negedge CLK);
        RST   = 1'b0;
        START = 1'b0;
        tests++;
        if ({BUSY, DONE, PASS, A, B, ERR_CNT} !== 8'b0) begin
            fails++;
            $display("FAIL rst_mid_state: got busy/done/pass/a/b/err=%b required 0", {BUSY, DONE, PASS, A, B, ERR_CNT});
        end
`ifdef AND2_EXERCISER_FAILCAP_EN
        tests++;
        if (FAIL_VALID !== 1'b0 || FAIL_VEC !== 2'b00) begin
            fails++;
            $display("FAIL rst_mid_failcap: got v=%b vec=%b required 0", FAIL_VALID, FAIL_VEC);
        end
`endif
        saw_done = 0;
        repeat (20) begin
            @(negedge CLK);
            if (DONE === 1'b1 || BUSY === 1'b1) saw_done++;
        end
        tests++;
        if (saw_done != 0) begin
            fails++;
            $display("FAIL rst_mid_quiet: got %0d active cycles required 0", saw_done);
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_stuck0();
        test_stuck1();
        test_nand();
        test_restart();
        test_back_to_back();
        test_reset_midrun();
        test_correct();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/and2_exerciser.md
AND2_EXERCISER -- requirements
Module: and2_exerciser

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2, giving the number of wait cycles between driving a vector and sampling F; the legal range is 1..15.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port START, input, 1 bit: request one full truth-table run, sampled only in IDLE.
REQ-005 The block SHALL have port A, output, 1 bit: operand A driven to the 2-input AND under test, registered.
REQ-006 The block SHALL have port B, output, 1 bit: operand B driven to the 2-input AND under test, registered.
REQ-007 The block SHALL have port F, input, 1 bit: the result returned by the gate under test.
REQ-008 The block SHALL have port BUSY, output, 1 bit: high in every state except IDLE.
REQ-009 The block SHALL have port DONE, output, 1 bit: a one-cycle pulse at the end of a run.
REQ-010 The block SHALL have port PASS, output, 1 bit: high when the last completed run had zero mismatches, held until the next START.
REQ-011 The block SHALL have port ERR_CNT, output, 3 bits: the mismatch count of the current or last run, with range 0..4.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, SETTLE, SAMPLE and FIN.
REQ-013 In IDLE, when START=1, the block SHALL on the next edge set vec=0, A=0, B=0, ERR_CNT=0, PASS=0, cnt=SETTLE-1, and enter SETTLE.
REQ-014 In SETTLE, when cnt>0 the block SHALL decrement cnt, and when cnt=0 it SHALL enter SAMPLE.
REQ-015 In SAMPLE, the block SHALL compare F against A&B and increment ERR_CNT by 1 on mismatch.
REQ-016 In SAMPLE, when vec<3 the block SHALL set vec=vec+1, A=vec_next[1], B=vec_next[0], reload cnt=SETTLE-1, and enter SETTLE.
REQ-017 In SAMPLE, when vec=3 the block SHALL enter FIN.
REQ-018 The vector order SHALL be AB = 00, 01, 10, 11.
REQ-019 In FIN, the block SHALL assert DONE for exactly one cycle, set PASS=(ERR_CNT==0) including the count from the final sample, return A and B to 0, and enter IDLE.
REQ-020 Latency SHALL be as follows: with START seen at edge 0, vector k is sampled in cycle (SETTLE+1)*(k+1), and DONE is high in cycle 4*(SETTLE+1)+1; for SETTLE=2, DONE is high in cycle 13.
REQ-021 START while BUSY=1 SHALL be ignored, with no restart and no effect on counters.
REQ-022 START held high continuously SHALL begin a new run on the cycle after FIN, so that runs are back-to-back.
REQ-023 ERR_CNT SHALL NOT wrap: 4 mismatches yields exactly 4.

Reset
REQ-024 RST=1 at any edge, including mid-run, SHALL force state=IDLE, A=0, B=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, vec=0 and cnt=0.
REQ-025 RST SHALL take priority over START.
REQ-026 No partial-run result SHALL survive reset.

Configuration
REQ-027 When the macro AND2_EXERCISER_FAILCAP_EN is defined, the block SHALL add output FAIL_VALID (1 bit) and output FAIL_VEC (2 bits), both latched in SAMPLE at the first mismatch of a run.
REQ-028 With AND2_EXERCISER_FAILCAP_EN defined, FAIL_VALID and FAIL_VEC SHALL be cleared by START and by RST.
REQ-029 With AND2_EXERCISER_FAILCAP_EN defined, later mismatches in the same run SHALL NOT overwrite FAIL_VEC.
REQ-030 When AND2_EXERCISER_FAILCAP_EN is undefined, neither port SHALL exist, and behaviour SHALL otherwise be identical.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (IDLE=0, SETTLE=1, SAMPLE=2, FIN=3), the vector count constant 4, and the ERR_CNT width constant 3.
REQ-032 A single sub-module, and2_settle_timer, SHALL implement the cnt load/decrement and its zero flag.
REQ-033 The vector register, comparison and FSM SHALL stay in the top module.

Verification
REQ-034 Scenario: correct AND gate on F, SETTLE=2, START pulsed -> DONE in cycle 13, PASS=1, ERR_CNT=0.
REQ-035 Scenario: F stuck at 0 -> ERR_CNT=1, PASS=0; with AND2_EXERCISER_FAILCAP_EN defined, FAIL_VEC=2'b11.
REQ-036 Scenario: F stuck at 1 -> ERR_CNT=3, PASS=0; with AND2_EXERCISER_FAILCAP_EN defined, FAIL_VEC=2'b00.
REQ-037 Scenario: F = NAND(A,B) -> ERR_CNT=4 with no wrap, PASS=0.
REQ-038 Scenario: START re-pulsed in cycle 5 of a run -> that pulse is ignored and DONE still occurs in cycle 13.
REQ-039 Scenario: RST asserted in cycle 7 of a run -> next cycle BUSY=0, A=B=0, ERR_CNT=0, PASS=0, and no DONE pulse.
